alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Instruction-level controller for the 8-bit ALU datapath (ADD/SUB/NOR/SHL/SHR/LD/RST).
- Accepts one operation at a time over a valid/ready handshake.
- Owns the accumulator and the carry/zero flag registers, and drives the ALU control and operand ports.
- Adds a multi-cycle MUL that iterates the ALU with shift-add; sits between the instruction source and the ALU.

Parameters:
MUL_BITS, 8, multiplier bits processed by MUL (legal 1..8); MUL takes 2*MUL_BITS EXEC cycles

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
instr_valid  input  1  instruction offered
instr_ready  output  1  controller can accept; high only in IDLE
instr_op  input  3  000 RST, 001 LD, 010 ADD, 011 SUB, 100 NOR, 101 SHL, 110 SHR, 111 MUL
instr_data  input  8  operand
alu_a  output  8  ALU operand a
alu_b  output  8  ALU operand b
alu_sel  output  2  ALU select: 10 ADD, 11 SUB, 01 NOR, 00 load/shift group
alu_load_shift  output  2  within group 00: 11 SHR, 01 SHL, 10 LD (pass a), 00 RST
alu_result  input  8  ALU result
alu_cout  input  1  ALU bit 8; carry for ADD, borrow for SUB
alu_zout  input  1  ALU zero flag
acc_out  output  8  accumulator
flag_c  output  1  registered carry flag
flag_z  output  1  registered zero flag
done  output  1  one-cycle pulse when the result is committed and visible

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE; acc_out=0x00, flag_c=0, flag_z=0, done=0.
  - Multiplier/multiplicand/product registers cleared.
  - instr_ready follows state, so it reads 1.
  - Handshake inputs are ignored until the first rising edge after release.
- Handshake:
  - Transfer happens on a rising edge with instr_valid=1 and instr_ready=1.
  - op and data are latched; the source may change them afterwards.
  - instr_ready=0 in every non-IDLE state. Valid while not ready has no effect.
- States: IDLE -> EXEC (single ops) or MUL_ADD/MUL_SHL (MUL) -> DONE -> IDLE.
- IDLE ALU drive: a=0x00, b=0x00, sel=00, load_shift=00.
- EXEC, one cycle, ALU driven combinationally from registers:
  - ADD/SUB/NOR: a=acc, b=operand.
  - SHL/SHR: a=acc, b=0x00.
  - LD: a=operand, b=0x00, load_shift=10.
  - RST: load_shift=00.
  - At the end of EXEC: acc<=alu_result, flag_z<=alu_zout.
  - flag_c<=alu_cout for ADD/SUB; flag_c<=0 for other single ops.
- DONE: done=1 for exactly one cycle; acc/flags are already updated. Next state is IDLE.
- Single-op latency:
  - Accept at edge N; acc updates at edge N+1; done is high during cycle N+1..N+2.
  - Next accept is possible at edge N+3.
- MUL (acc = low 8 bits of acc * operand):
  - On accept: mcand<=acc, mplier<=operand, prod<=0, iter<=0, sticky carry cleared.
  - MUL_ADD:
    - If mplier[0]=1: a=prod, b=mcand, sel=10.
    - Else LD: a=prod, sel=00, load_shift=10. Latency is fixed regardless of bits.
    - prod<=alu_result; sticky carry |= alu_cout.
  - MUL_SHL: a=mcand, SHL; mcand<=alu_result; mplier<=mplier>>1 (internal shift); iter+1.
  - After MUL_BITS iterations:
    - acc<=prod, flag_z<=(prod==0).
    - flag_c<=sticky carry OR any bit shifted out of mcand that would have been added (overflow indicator).
  - MUL latency: accept at edge N, 2*MUL_BITS ALU cycles, done high one cycle after the last commit. Default: done in cycle N+17.
- Arithmetic is 8-bit wrap. SUB carry=1 means borrow (acc<operand).
- Reset mid-operation aborts immediately; there is no partial commit and done is not pulsed.

Optional Feature:
- Macro: ALU_SEQ_SAT_EN.
- Defined:
  - ADD with alu_cout=1 commits acc=0xFF, flag_z=0.
  - SUB with alu_cout=1 (borrow) commits acc=0x00, flag_z=1.
  - MUL with overflow commits acc=0xFF.
  - flag_c still reports the raw carry/borrow/overflow.
- Undefined: all results wrap modulo 256 as specified above.

Test Plan:
- Reset release, then LD 0x3C, ADD 0x10 -> acc=0x4C, c=0, z=0; done pulses once per op, 3 cycles apart.
- LD 0xF0, ADD 0x20 -> acc=0x10, c=1; with ALU_SEQ_SAT_EN -> acc=0xFF, c=1.
- LD 0x05, SUB 0x05 -> acc=0x00, z=1, c=0; then SUB 0x01 -> acc=0xFF, c=1 (SAT: 0x00, z=1).
- LD 0x81: SHL -> acc=0x02; SHR -> 0x01; NOR 0xFE -> 0x00, z=1; RST -> 0x00, c=0.
- LD 0x0D, MUL 0x0B -> acc=0x8F, c=0, done in cycle 17 after accept; LD 0x20, MUL 0x10 -> acc=0x00, z=1, c=1; instr_ready=0 throughout.
- Assert reset_n low during MUL iteration 4 -> acc=0, flags=0, no done, ready=1; a new LD after release completes normally.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction handshake and ALU control/result bundle for alu_sequencer
interface alu_sequencer_if;
   logic       instr_valid;
   logic       instr_ready;
   logic [2:0] instr_op;
   logic [7:0] instr_data;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [1:0] alu_sel;
   logic [1:0] alu_load_shift;
   logic [7:0] alu_result;
   logic       alu_cout;
   logic       alu_zout;

   modport master (
      output instr_valid, instr_op, instr_data, alu_result, alu_cout, alu_zout,
      input  instr_ready, alu_a, alu_b, alu_sel, alu_load_shift
   );

   modport slave (
      input  instr_valid, instr_op, instr_data, alu_result, alu_cout, alu_zout,
      output instr_ready, alu_a, alu_b, alu_sel, alu_load_shift
   );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - accumulator/flag controller driving an external 8-bit ALU, with shift-add MUL
// Optional saturating commits when ALU_SEQ_SAT_EN is defined.
module alu_sequencer #(
   parameter int MUL_BITS = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   alu_sequencer_if.slave   bus,
   output logic [7:0]       acc_out,
   output logic             flag_c,
   output logic             flag_z,
   output logic             done
);
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_EXEC    = 3'd1;
   localparam logic [2:0] ST_MUL_ADD = 3'd2;
   localparam logic [2:0] ST_MUL_SHL = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   localparam logic [2:0] OP_RST = 3'b000;
   localparam logic [2:0] OP_LD  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_NOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   localparam logic [3:0] LAST_ITER = 4'(MUL_BITS - 1);

   logic [2:0] state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [7:0] operand_q, operand_d;
   logic [7:0] acc_q, acc_d;
   logic       fc_q, fc_d;
   logic       fz_q, fz_d;
   logic [7:0] mcand_q, mcand_d;
   logic [7:0] mplier_q, mplier_d;
   logic [7:0] prod_q, prod_d;
   logic [3:0] iter_q, iter_d;
   logic       sticky_q, sticky_d;
   logic       lost_q, lost_d;

   assign bus.instr_ready = (state_q == ST_IDLE);
   assign acc_out         = acc_q;
   assign flag_c          = fc_q;
   assign flag_z          = fz_q;
   assign done            = (state_q == ST_DONE);

   always_comb begin
      bus.alu_a          = 8'h00;
      bus.alu_b          = 8'h00;
      bus.alu_sel        = 2'b00;
      bus.alu_load_shift = 2'b00;
      case (state_q)
         ST_EXEC: begin
            case (op_q)
               OP_ADD: begin bus.alu_a = acc_q; bus.alu_b = operand_q; bus.alu_sel = 2'b10; end
               OP_SUB: begin bus.alu_a = acc_q; bus.alu_b = operand_q; bus.alu_sel = 2'b11; end
               OP_NOR: begin bus.alu_a = acc_q; bus.alu_b = operand_q; bus.alu_sel = 2'b01; end
               OP_SHL: begin bus.alu_a = acc_q; bus.alu_load_shift = 2'b01; end
               OP_SHR: begin bus.alu_a = acc_q; bus.alu_load_shift = 2'b11; end
               OP_LD:  begin bus.alu_a = operand_q; bus.alu_load_shift = 2'b10; end
               default: ;
            endcase
         end
         ST_MUL_ADD: begin
            bus.alu_a = prod_q;
            // A zero multiplier bit still spends the cycle as a pass-through so latency is data-independent.
            if (mplier_q[0]) begin
               bus.alu_b   = mcand_q;
               bus.alu_sel = 2'b10;
            end else begin
               bus.alu_load_shift = 2'b10;
            end
         end
         ST_MUL_SHL: begin
            bus.alu_a          = mcand_q;
            bus.alu_load_shift = 2'b01;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      operand_d = operand_q;
      acc_d     = acc_q;
      fc_d      = fc_q;
      fz_d      = fz_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      prod_d    = prod_q;
      iter_d    = iter_q;
      sticky_d  = sticky_q;
      lost_d    = lost_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.instr_valid) begin
               op_d      = bus.instr_op;
               operand_d = bus.instr_data;
               if (bus.instr_op == OP_MUL) begin
                  mcand_d  = acc_q;
                  mplier_d = bus.instr_data;
                  prod_d   = 8'h00;
                  iter_d   = 4'd0;
                  sticky_d = 1'b0;
                  lost_d   = 1'b0;
                  state_d  = ST_MUL_ADD;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            acc_d = bus.alu_result;
            fz_d  = bus.alu_zout;
            fc_d  = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? bus.alu_cout : 1'b0;
`ifdef ALU_SEQ_SAT_EN
            if (bus.alu_cout && (op_q == OP_ADD)) begin
               acc_d = 8'hFF;
               fz_d  = 1'b0;
            end else if (bus.alu_cout && (op_q == OP_SUB)) begin
               acc_d = 8'h00;
               fz_d  = 1'b1;
            end
`endif
            state_d = ST_DONE;
         end
         ST_MUL_ADD: begin
            prod_d = bus.alu_result;
            // Overflow if this add carries, or if it adds a multiplicand that already lost high bits.
            sticky_d = sticky_q | (mplier_q[0] & (bus.alu_cout | lost_q));
            state_d  = ST_MUL_SHL;
         end
         ST_MUL_SHL: begin
            mcand_d  = bus.alu_result;
            mplier_d = {1'b0, mplier_q[7:1]};
            lost_d   = lost_q | mcand_q[7];
            iter_d   = iter_q + 4'd1;
            if (iter_q == LAST_ITER) begin
               acc_d = prod_q;
               fz_d  = (prod_q == 8'h00);
               fc_d  = sticky_q;
`ifdef ALU_SEQ_SAT_EN
               if (sticky_q) begin
                  acc_d = 8'hFF;
                  fz_d  = 1'b0;
               end
`endif
               state_d = ST_DONE;
            end else begin
               state_d = ST_MUL_ADD;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_RST;
         operand_q <= 8'h00;
         acc_q     <= 8'h00;
         fc_q      <= 1'b0;
         fz_q      <= 1'b0;
         mcand_q   <= 8'h00;
         mplier_q  <= 8'h00;
         prod_q    <= 8'h00;
         iter_q    <= 4'd0;
         sticky_q  <= 1'b0;
         lost_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         operand_q <= operand_d;
         acc_q     <= acc_d;
         fc_q      <= fc_d;
         fz_q      <= fz_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         prod_q    <= prod_d;
         iter_q    <= iter_d;
         sticky_q  <= sticky_d;
         lost_q    <= lost_d;
      end
   end
endmodule
